// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage: combinational decode of the fetch beat into a registered
// output slot backed by an optional skid entry, with flush and a saturating illegal counter.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned M_EXT = 0,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTR,
  input  logic [XLEN-1:0]  PC,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_PC,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic [4:0]       RD,
  output logic [XLEN-1:0]  IMM,
  output logic             OP1SEL,
  output logic             OP2SEL,
  output logic             REG_WRITE_EN,
  output logic [1:0]       WB_SEL,
  output logic [4:0]       ALUOP,
  output logic [2:0]       BRANCH_JUMP,
  output logic [2:0]       IMM_SEL,
  output logic [3:0]       READ_WRITE,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] ILLEGAL_CNT
);

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            op1sel;
    logic            op2sel;
    logic            reg_write_en;
    logic [1:0]      wb_sel;
    logic [4:0]      aluop;
    logic [2:0]      branch_jump;
    logic [2:0]      imm_sel;
    logic [3:0]      read_write;
    logic            illegal;
  } beat_t;

  function automatic beat_t nop_beat();
    beat_t b;
    b             = '0;
    b.branch_jump = 3'b010;
    return b;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] sh_hi;
  logic       load_ok;

  assign opcode = INSTR[6:0];
  assign funct3 = INSTR[14:12];
  assign funct7 = INSTR[31:25];
  // On RV64 bit 25 is shamt[5], so only the upper six bits qualify a shift.
  assign sh_hi  = (XLEN == 64) ? {INSTR[31:26], 1'b0} : INSTR[31:25];

  always_comb begin
    load_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok = 1'b1;
      3'b011, 3'b110:                         load_ok = (XLEN == 64);
      default:                                load_ok = 1'b0;
    endcase
  end

  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i32 = {{20{INSTR[31]}}, INSTR[31:20]};
  assign imm_s32 = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
  assign imm_b32 = {{19{INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
  assign imm_u32 = {INSTR[31:12], 12'h000};
  assign imm_j32 = {{11{INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};
  assign imm_i   = XLEN'(imm_i32);
  assign imm_s   = XLEN'(imm_s32);
  assign imm_b   = XLEN'(imm_b32);
  assign imm_u   = XLEN'(imm_u32);
  assign imm_j   = XLEN'(imm_j32);

  beat_t dec;
  logic  legal;

  always_comb begin
    dec     = nop_beat();
    dec.pc  = PC;
    dec.rs1 = INSTR[19:15];
    dec.rs2 = INSTR[24:20];
    dec.rd  = INSTR[11:7];
    legal   = 1'b0;
    case (opcode)
      OpcLui: begin
        legal            = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.wb_sel       = 2'b10;
        dec.imm          = imm_u;
      end
      OpcAuipc: begin
        legal            = 1'b1;
        dec.op1sel       = 1'b1;
        dec.op2sel       = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.imm          = imm_u;
      end
      OpcJal: begin
        legal            = 1'b1;
        dec.op1sel       = 1'b1;
        dec.op2sel       = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.wb_sel       = 2'b11;
        dec.branch_jump  = 3'b011;
        dec.imm_sel      = 3'b001;
        dec.imm          = imm_j;
      end
      OpcJalr: begin
        legal            = (funct3 == 3'b000);
        dec.op2sel       = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.wb_sel       = 2'b11;
        dec.branch_jump  = 3'b011;
        dec.imm_sel      = 3'b100;
        dec.imm          = imm_i;
      end
      OpcBranch: begin
        legal           = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec.op1sel      = 1'b1;
        dec.op2sel      = 1'b1;
        dec.imm_sel     = 3'b011;
        dec.branch_jump = funct3;
        dec.imm         = imm_b;
      end
      OpcLoad: begin
        legal            = load_ok;
        dec.op2sel       = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.wb_sel       = 2'b01;
        dec.imm_sel      = 3'b100;
        dec.imm          = imm_i;
        case (funct3)
          3'b000:  dec.read_write = 4'b1000;
          3'b001:  dec.read_write = 4'b1001;
          3'b010:  dec.read_write = 4'b1010;
          3'b100:  dec.read_write = 4'b1100;
          3'b101:  dec.read_write = 4'b1101;
          default: dec.read_write = 4'b0000;
        endcase
      end
      OpcStore: begin
        legal       = (funct3 <= 3'b010);
        dec.op2sel  = 1'b1;
        dec.imm_sel = 3'b010;
        dec.imm     = imm_s;
        case (funct3)
          3'b000:  dec.read_write = 4'b1011;
          3'b001:  dec.read_write = 4'b1110;
          3'b010:  dec.read_write = 4'b1111;
          default: dec.read_write = 4'b0000;
        endcase
      end
      OpcOpImm: begin
        legal            = 1'b1;
        dec.op2sel       = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.imm_sel      = 3'b100;
        dec.imm          = imm_i;
        dec.aluop        = {funct3, 2'b00};
        case (funct3)
          3'b001: begin
            legal       = (sh_hi == 7'b0000000);
            dec.imm_sel = 3'b101;
            dec.aluop   = {funct3, sh_hi[5], sh_hi[0]};
          end
          3'b101: begin
            legal       = (sh_hi == 7'b0000000) || (sh_hi == 7'b0100000);
            dec.imm_sel = 3'b101;
            dec.aluop   = {funct3, sh_hi[5], sh_hi[0]};
          end
          3'b011:  dec.imm_sel = 3'b110;
          default: ;
        endcase
      end
      OpcOp: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                ((funct7 == 7'b0000001) && (M_EXT != 0));
        dec.reg_write_en = 1'b1;
        dec.aluop        = {funct3, funct7[5], funct7[0]};
      end
      OpcMiscMem: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
    // Illegal beats keep their addresses for trap reporting but carry no control effect.
    if (!legal) begin
      dec         = nop_beat();
      dec.pc      = PC;
      dec.rs1     = INSTR[19:15];
      dec.rs2     = INSTR[24:20];
      dec.rd      = INSTR[11:7];
      dec.illegal = 1'b1;
    end
  end

  beat_t            out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, out_free, out_fire;

  assign IN_READY = (SKID != 0) ? in_ready_q : (in_ready_q & (!out_valid_q | OUT_READY));
  assign accept   = IN_VALID & IN_READY;
  assign out_free = !out_valid_q | OUT_READY;
  assign out_fire = out_valid_q & OUT_READY;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (FLUSH) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = dec;
        end
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && out_q.illegal && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_q        <= nop_beat();
      skid_q       <= nop_beat();
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign OUT_VALID    = out_valid_q;
  assign OUT_PC       = out_q.pc;
  assign RS1          = out_q.rs1;
  assign RS2          = out_q.rs2;
  assign RD           = out_q.rd;
  assign IMM          = out_q.imm;
  assign OP1SEL       = out_q.op1sel;
  assign OP2SEL       = out_q.op2sel;
  assign REG_WRITE_EN = out_q.reg_write_en;
  assign WB_SEL       = out_q.wb_sel;
  assign ALUOP        = out_q.aluop;
  assign BRANCH_JUMP  = out_q.branch_jump;
  assign IMM_SEL      = out_q.imm_sel;
  assign READ_WRITE   = out_q.read_write;
  assign ILLEGAL      = out_q.illegal;
  assign ILLEGAL_CNT  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage: two instances (M_EXT=0/CNT_W=16 and M_EXT=1/CNT_W=2)
// share one stimulus stream and are checked against a queue-based reference model.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RESET_N, IN_VALID, FLUSH, OUT_READY;
  logic [31:0] INSTR, PC;

  always #5 CLK = ~CLK;

  logic        a0_rdy, a0_ov, a0_op1, a0_op2, a0_rwe, a0_ill;
  logic [31:0] a0_pc, a0_imm;
  logic [4:0]  a0_rs1, a0_rs2, a0_rd, a0_alu;
  logic [1:0]  a0_wb;
  logic [2:0]  a0_bj, a0_isel;
  logic [3:0]  a0_rw;
  logic [15:0] a0_cnt;

  logic        a1_rdy, a1_ov, a1_op1, a1_op2, a1_rwe, a1_ill;
  logic [31:0] a1_pc, a1_imm;
  logic [4:0]  a1_rs1, a1_rs2, a1_rd, a1_alu;
  logic [1:0]  a1_wb;
  logic [2:0]  a1_bj, a1_isel;
  logic [3:0]  a1_rw;
  logic [1:0]  a1_cnt;

  decode_stage #(.XLEN(32), .M_EXT(0), .SKID(1), .CNT_W(16)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(a0_rdy), .INSTR(INSTR),
    .PC(PC), .FLUSH(FLUSH), .OUT_VALID(a0_ov), .OUT_READY(OUT_READY), .OUT_PC(a0_pc),
    .RS1(a0_rs1), .RS2(a0_rs2), .RD(a0_rd), .IMM(a0_imm), .OP1SEL(a0_op1), .OP2SEL(a0_op2),
    .REG_WRITE_EN(a0_rwe), .WB_SEL(a0_wb), .ALUOP(a0_alu), .BRANCH_JUMP(a0_bj),
    .IMM_SEL(a0_isel), .READ_WRITE(a0_rw), .ILLEGAL(a0_ill), .ILLEGAL_CNT(a0_cnt)
  );

  decode_stage #(.XLEN(32), .M_EXT(1), .SKID(1), .CNT_W(2)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(a1_rdy), .INSTR(INSTR),
    .PC(PC), .FLUSH(FLUSH), .OUT_VALID(a1_ov), .OUT_READY(OUT_READY), .OUT_PC(a1_pc),
    .RS1(a1_rs1), .RS2(a1_rs2), .RD(a1_rd), .IMM(a1_imm), .OP1SEL(a1_op1), .OP2SEL(a1_op2),
    .REG_WRITE_EN(a1_rwe), .WB_SEL(a1_wb), .ALUOP(a1_alu), .BRANCH_JUMP(a1_bj),
    .IMM_SEL(a1_isel), .READ_WRITE(a1_rw), .ILLEGAL(a1_ill), .ILLEGAL_CNT(a1_cnt)
  );

  logic [35:0] ct0, ct1;
  assign ct0 = {a0_rs1, a0_rs2, a0_rd, a0_op1, a0_op2, a0_rwe, a0_wb, a0_alu, a0_bj, a0_isel,
                a0_rw, a0_ill};
  assign ct1 = {a1_rs1, a1_rs2, a1_rd, a1_op1, a1_op2, a1_rwe, a1_wb, a1_alu, a1_bj, a1_isel,
                a1_rw, a1_ill};

  localparam logic [35:0] NopCtl = {15'd0, 3'd0, 2'd0, 5'd0, 3'b010, 3'd0, 4'd0, 1'b0};

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        op1, op2, rwe;
    logic [1:0]  wb;
    logic [4:0]  alu;
    logic [2:0]  bj, isel;
    logic [3:0]  rw;
    logic        ill;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t q[$];
  int    m_cnt0, m_cnt1;
  bit    m_rdy;
  int    n_cmp, n_bad;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected decode, written straight from the instruction tables.
  function automatic exp_t ref_decode(input logic [31:0] i, input bit mext);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    int         v;
    e = '0; e.bj = 3'b010; f3 = i[14:12]; f7 = i[31:25]; ok = 0; v = 0;
    case (i[6:0])
      7'h37: begin ok = 1; e.rwe = 1; e.wb = 2; v = {i[31:12], 12'h0}; end
      7'h17: begin ok = 1; e.op1 = 1; e.op2 = 1; e.rwe = 1; v = {i[31:12], 12'h0}; end
      7'h6F: begin
        ok = 1; e.op1 = 1; e.op2 = 1; e.rwe = 1; e.wb = 3; e.bj = 3; e.isel = 1;
        v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      end
      7'h67: begin
        ok = (f3 == 0); e.op2 = 1; e.rwe = 1; e.wb = 3; e.bj = 3; e.isel = 4;
        v = $signed(i[31:20]);
      end
      7'h63: begin
        ok = (f3 != 2) && (f3 != 3); e.op1 = 1; e.op2 = 1; e.isel = 3; e.bj = f3;
        v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      end
      7'h03: begin
        e.op2 = 1; e.rwe = 1; e.wb = 1; e.isel = 4; v = $signed(i[31:20]);
        case (f3)
          0: begin ok = 1; e.rw = 4'b1000; end
          1: begin ok = 1; e.rw = 4'b1001; end
          2: begin ok = 1; e.rw = 4'b1010; end
          4: begin ok = 1; e.rw = 4'b1100; end
          5: begin ok = 1; e.rw = 4'b1101; end
          default: ok = 0;
        endcase
      end
      7'h23: begin
        e.op2 = 1; e.isel = 2; v = $signed({i[31:25], i[11:7]});
        case (f3)
          0: begin ok = 1; e.rw = 4'b1011; end
          1: begin ok = 1; e.rw = 4'b1110; end
          2: begin ok = 1; e.rw = 4'b1111; end
          default: ok = 0;
        endcase
      end
      7'h13: begin
        ok = 1; e.op2 = 1; e.rwe = 1; e.isel = 4; v = $signed(i[31:20]); e.alu = {f3, 2'b00};
        if (f3 == 1) begin ok = (f7 == 0); e.isel = 5; e.alu = {f3, f7[5], f7[0]}; end
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20); e.isel = 5; e.alu = {f3, f7[5], f7[0]};
        end
        if (f3 == 3) e.isel = 6;
      end
      7'h33: begin
        ok = (f7 == 0) || ((f7 == 7'h20) && (f3 == 0 || f3 == 5)) || ((f7 == 1) && mext);
        e.rwe = 1; e.alu = {f3, f7[5], f7[0]};
      end
      7'h0F: ok = 1;
      default: ok = 0;
    endcase
    e.imm = v;
    if (!ok) begin e = '0; e.bj = 3'b010; e.ill = 1; end
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    return e;
  endfunction

  // Advance the model across one rising edge using the inputs held during that cycle.
  task automatic tick();
    beat_t b;
    exp_t  h;
    bit    acc, del;
    @(posedge CLK);
    if (!RESET_N) begin
      q.delete(); m_cnt0 = 0; m_cnt1 = 0; m_rdy = 0;
    end else begin
      acc = IN_VALID && m_rdy;
      del = (q.size() != 0) && OUT_READY;
      if (del) begin
        h = ref_decode(q[0].instr, 1'b0);
        if (h.ill && m_cnt0 < 65535) m_cnt0++;
        h = ref_decode(q[0].instr, 1'b1);
        if (h.ill && m_cnt1 < 3) m_cnt1++;
        void'(q.pop_front());
      end
      if (FLUSH) q.delete();
      else if (acc) begin b.instr = INSTR; b.pc = PC; q.push_back(b); end
      m_rdy = (q.size() < 2);
    end
    #1;
  endtask

  task automatic check_all();
    exp_t e0, e1;
    check_val("in_ready", a0_rdy, m_rdy);
    check_val("in_ready_m", a1_rdy, m_rdy);
    check_val("out_valid", a0_ov, q.size() != 0);
    check_val("out_valid_m", a1_ov, q.size() != 0);
    check_val("ill_cnt", a0_cnt, m_cnt0);
    check_val("ill_cnt_m", a1_cnt, m_cnt1);
    if (q.size() != 0) begin
      e0 = ref_decode(q[0].instr, 1'b0);
      e1 = ref_decode(q[0].instr, 1'b1);
      check_val("pc_imm", {a0_pc, a0_imm}, {q[0].pc, e0.imm});
      check_val("ctl", ct0, e0[67:32]);
      check_val("pc_imm_m", {a1_pc, a1_imm}, {q[0].pc, e1.imm});
      check_val("ctl_m", ct1, e1[67:32]);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    IN_VALID  = v;
    INSTR     = ins;
    OUT_READY = ordy;
    FLUSH     = fl;
    PC        = $urandom & 32'hFFFF_FFFC;
    #1;
    check_all();
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [6:0]  f7s [4];
    logic [31:0] r;
    int          sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h7F};
    r   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 10) begin
      r[6:0] = ops[sel];
      if (sel >= 7) r[31:25] = f7s[$urandom_range(0, 3)];
    end
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ov"}, a0_ov, 0);
    check_val({tag, "_rdy"}, a0_rdy, 0);
    check_val({tag, "_cnt"}, a0_cnt, 0);
    check_val({tag, "_cnt_m"}, a1_cnt, 0);
    check_val({tag, "_ctl"}, ct0, NopCtl);
    check_val({tag, "_pc_imm"}, {a0_pc, a0_imm}, 0);
  endtask

  initial begin
    int acc, k, del;
    int s0, s1;
    n_cmp = 0; n_bad = 0; m_cnt0 = 0; m_cnt1 = 0; m_rdy = 0;
    RESET_N = 0; IN_VALID = 0; FLUSH = 0; OUT_READY = 0; INSTR = 0; PC = 0;
    tick(); tick();
    check_reset_state("rst");
    RESET_N = 1;
    tick();
    check_val("rdy_after_rst", a0_rdy, 1);

    step(1, 32'hFFF10093, 1, 0);  // addi x1,x2,-1
    check_val("addi_ov", a0_ov, 1);
    check_val("addi_rd", a0_rd, 1);
    check_val("addi_rs1", a0_rs1, 2);
    check_val("addi_ctl", {a0_op1, a0_op2, a0_rwe, a0_wb, a0_alu}, {3'b011, 2'b00, 5'b00000});
    check_val("addi_isel", a0_isel, 3'b100);
    check_val("addi_imm", a0_imm, 32'hFFFF_FFFF);
    check_val("addi_ill", a0_ill, 0);
    step(1, 32'h00112623, 1, 0);  // sw x1,12(x2)
    check_val("sw_rw", a0_rw, 4'b1111);
    check_val("sw_isel", a0_isel, 3'b010);
    check_val("sw_imm", a0_imm, 12);
    check_val("sw_rwe", a0_rwe, 0);
    step(1, 32'hFFDFF0EF, 1, 0);  // jal x1,-4
    check_val("jal_bj", a0_bj, 3'b011);
    check_val("jal_wb", a0_wb, 2'b11);
    check_val("jal_imm", a0_imm, 32'hFFFF_FFFC);
    step(1, 32'h022081B3, 1, 0);  // mul x3,x1,x2
    check_val("mul_ill", a0_ill, 1);
    check_val("mul_rwe", a0_rwe, 0);
    check_val("mul_bj", a0_bj, 3'b010);
    check_val("mul_m_ill", a1_ill, 0);
    check_val("mul_m_alu", a1_alu, 5'b00001);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Four beats against a three-cycle stall: only two fit, then all drain in order.
    acc = 0; k = 0; del = 0;
    for (int c = 0; c < 20 && del < 4; c++) begin
      IN_VALID  = (k < 4);
      INSTR     = 32'h0010_0013 | ((k + 1) << 7);
      OUT_READY = (c >= 3);
      FLUSH     = 0;
      PC        = 32'h100 + 4 * k;
      #1;
      check_all();
      if (c == 3) begin
        check_val("skid_acc2", acc, 2);
        check_val("skid_rdy_lo", a0_rdy, 0);
      end
      if (a0_ov && OUT_READY) begin
        check_val("skid_order", a0_rd, del + 1);
        del++;
      end
      if (IN_VALID && a0_rdy) begin acc++; k++; end
      tick();
    end
    check_val("skid_delivered", del, 4);

    // Flush with both entries full and a concurrent input beat.
    step(1, 32'h0000_0000, 0, 0);
    step(1, 32'h0000_0000, 0, 0);
    s0 = m_cnt0; s1 = m_cnt1;
    step(1, 32'hFFF10093, 0, 1);
    check_val("flush_ov", a0_ov, 0);
    check_val("flush_rdy", a0_rdy, 1);
    check_val("flush_cnt", a0_cnt, s0);
    check_val("flush_cnt_m", a1_cnt, s1);
    step(0, 0, 1, 0);
    check_val("flush_gone", a0_ov, 0);
    step(0, 0, 1, 0);

    // Counter saturation on the 2-bit instance.
    RESET_N = 0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    RESET_N = 1;
    step(0, 0, 1, 0);
    for (int n = 0; n < 5; n++) step(1, 32'h0000_0000, 1, 0);
    step(0, 0, 1, 0);
    check_val("sat_cnt_m", a1_cnt, 3);
    check_val("sat_cnt", a0_cnt, 5);

    for (int c = 0; c < 3000; c++) begin
      RESET_N = !(c == 1500 || c == 1501);
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
      if (c == 1501) check_reset_state("midrst");
      if (c == 1502) check_val("midrst_rdy", a0_rdy, 1);
    end
    step(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage with a valid/ready handshake on both sides.
- Produces the core's existing control-word encoding plus register addresses, a sign-extended immediate and the passed-through PC.
- Adds illegal-instruction detection, optional M-extension decode, a skid buffer, flush and a saturating illegal counter.
- Sits between fetch and the register-file/ALU stage.

Parameters:
XLEN, 32, datapath width for PC/IMM (32 or 64)
M_EXT, 0, 1 = accept OP funct7=0000001 (MUL/DIV group) as legal
SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single register, IN_READY = !OUT_VALID | OUT_READY
CNT_W, 16, width of ILLEGAL_CNT

Ports:
CLK  in  1  clock
RESET_N  in  1  synchronous, active-low reset
IN_VALID  in  1  fetch beat valid
IN_READY  out  1  stage can accept
INSTR  in  32  instruction word
PC  in  XLEN  instruction address
FLUSH  in  1  synchronous discard of all held beats
OUT_VALID  out  1  decoded beat valid
OUT_READY  in  1  downstream accepts
OUT_PC  out  XLEN  PC of the output beat
RS1, RS2, RD  out  5 each  INSTR[19:15], [24:20], [11:7]
IMM  out  XLEN  sign-extended immediate; 0 for R-type/illegal
OP1SEL, OP2SEL, REG_WRITE_EN  out  1 each  control bits
WB_SEL  out  2  00 ALU, 01 load, 10 imm (LUI), 11 PC+4
ALUOP  out  5  {funct3, funct7[5], funct7[0]} for OP/OP-IMM; 0 otherwise
BRANCH_JUMP  out  3  funct3 for branches, 011 jumps, 010 none
IMM_SEL  out  3  format select
READ_WRITE  out  4  memory access code
ILLEGAL  out  1  output beat is an illegal instruction
ILLEGAL_CNT  out  CNT_W  saturating count of illegal beats delivered

Behaviour:
- Reset (RESET_N low at a CLK edge): OUT_VALID=0, IN_READY=0, ILLEGAL_CNT=0; all data/control outputs are NOP values (OP1SEL=OP2SEL=REG_WRITE_EN=0, WB_SEL=00, ALUOP=0, BRANCH_JUMP=010, IMM_SEL=000, READ_WRITE=0000, ILLEGAL=0, IMM/PC/regs=0). IN_READY=1 from the first cycle after release. Reset overrides FLUSH and handshakes.
- Latency: a beat accepted at edge N (IN_VALID&IN_READY) appears with OUT_VALID=1 after edge N. Throughput is 1/cycle when OUT_READY=1.
- While OUT_VALID&!OUT_READY, all outputs hold stable.
- SKID=1: a beat arriving during a stall goes to the skid entry; IN_READY deasserts the next cycle. When the output drains, the skid entry moves to the output at the next edge, so order is preserved. IN_READY is a flop.
- FLUSH=1 at an edge clears both entries; an input handshake in the same cycle is dropped. ILLEGAL_CNT is not cleared. OUT_VALID=0 the next cycle.
- Opcode decode:
  - LUI: REG_WRITE_EN=1, WB_SEL=10, IMM U.
  - AUIPC: OP1SEL=1, OP2SEL=1, REG_WRITE_EN=1, IMM U.
  - JAL: OP1SEL=1, OP2SEL=1, REG_WRITE_EN=1, WB_SEL=11, BRANCH_JUMP=011, IMM_SEL=001.
  - JALR: OP2SEL=1, REG_WRITE_EN=1, WB_SEL=11, BRANCH_JUMP=011, IMM_SEL=100.
  - BRANCH: OP1SEL=1, OP2SEL=1, IMM_SEL=011.
  - LOAD: OP2SEL=1, REG_WRITE_EN=1, WB_SEL=01, IMM_SEL=100.
  - STORE: OP2SEL=1, IMM_SEL=010.
  - OP-IMM: OP2SEL=1, REG_WRITE_EN=1, IMM_SEL=100. Exceptions: 101 for SLLI/SRLI/SRAI, 110 for SLTIU. funct7 bits are used in ALUOP only for shifts.
  - OP: REG_WRITE_EN=1, IMM_SEL=000.
  - MISC-MEM (FENCE): legal NOP.
- READ_WRITE: LB 1000, LH 1001, LW 1010, LBU 1100, LHU 1101, SB 1011, SH 1110, SW 1111; 0000 otherwise.
- ILLEGAL=1 when any of the following holds:
  - INSTR[1:0]!=11, or opcode is unlisted (incl. SYSTEM).
  - JALR funct3!=000.
  - BRANCH funct3 is 010 or 011.
  - LOAD funct3 is 011, 110 or 111 (XLEN=32).
  - STORE funct3 > 010.
  - OP funct7 is not 0000000, or 0100000 with funct3 000/101, or 0000001 with M_EXT=1.
  - Shift-imm upper bits are not 0000000/0100000 (SRAI only for 0100000).
  On ILLEGAL, every control output takes its NOP value; RS/RD/PC still pass through; IMM=0.
- IMM: I/S/B/U/J per RISC-V, sign-extended from bit 31 to XLEN.
- ILLEGAL_CNT increments on OUT_VALID&OUT_READY&ILLEGAL and saturates at all-ones.

Test Plan:
- 0xFFF10093 (addi x1,x2,-1), OUT_READY=1 → next cycle OUT_VALID=1, RD=1, RS1=2, OP2SEL=1, REG_WRITE_EN=1, WB_SEL=00, ALUOP=00000, IMM_SEL=100, IMM=0xFFFFFFFF, ILLEGAL=0.
- 0x00112623 (sw x1,12(x2)) → READ_WRITE=1111, IMM_SEL=010, IMM=12, REG_WRITE_EN=0. 0xFFDFF0EF (jal x1,-4) → BRANCH_JUMP=011, WB_SEL=11, IMM=0xFFFFFFFC.
- 0x022081B3 (mul x3,x1,x2): M_EXT=0 → ILLEGAL=1, REG_WRITE_EN=0, BRANCH_JUMP=010. M_EXT=1 → ILLEGAL=0, ALUOP=00001.
- SKID=1, stream 4 beats while OUT_READY=0 for 3 cycles → exactly 2 accepted, IN_READY=0 afterwards, then all 4 delivered in order with no loss or duplication.
- Two beats held plus FLUSH=1 with IN_VALID=1 → next cycle OUT_VALID=0, flushed beats never appear, ILLEGAL_CNT unchanged.
- CNT_W=2, deliver 5 illegal beats → ILLEGAL_CNT=3. RESET_N=0 mid-stream → OUT_VALID=0, ILLEGAL_CNT=0, NOP outputs, IN_READY=1 one cycle after release.
